// File: rtl/traffic_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_timer
// Brief    : Down-counting RED -> GREEN -> YELLOW phase timer with
//            programmable per-phase durations loaded over a valid/ready port.
//            The countdown decrement is a borrow-chain subtract of one.
// Options  : PED_REQUEST_EN - adds ped_req, which shortens a GREEN phase.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_phase_timer #(
  parameter int               WIDTH      = 4,
  parameter logic [WIDTH-1:0] RED_DEF    = WIDTH'(9),
  parameter logic [WIDTH-1:0] GREEN_DEF  = WIDTH'(9),
  parameter logic [WIDTH-1:0] YELLOW_DEF = WIDTH'(2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
`ifdef PED_REQUEST_EN
  input  logic             ped_req,
`endif
  input  logic             hold,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [1:0]       load_phase,
  input  logic [WIDTH-1:0] load_value,
  output logic [2:0]       light,
  output logic [WIDTH-1:0] remaining,
  output logic             phase_done
);

  // Phase encoding; 2'b11 is illegal and recovers to RED.
  typedef enum logic [1:0] {
    ST_RED    = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] remaining_q;
  logic [WIDTH-1:0] remaining_d;
  logic             done_q;
  logic             done_d;

  logic [WIDTH-1:0] dur_red_q;
  logic [WIDTH-1:0] dur_green_q;
  logic [WIDTH-1:0] dur_yellow_q;

  logic             step;
  logic             rem_zero;
  logic             rem_gt_one;
  logic             transition;
  logic             load_fire;

  // Borrow-chain subtractor computing remaining_q - 1.
  logic [WIDTH:0]   borrow;
  logic [WIDTH-1:0] rem_dec;

  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_borrow_chain
    assign rem_dec[i]    = remaining_q[i] ^ borrow[i];
    assign borrow[i + 1] = ~remaining_q[i] & borrow[i];
  end

  // A borrow out of the top bit happens only when subtracting from zero.
  assign rem_zero   = borrow[WIDTH];
  assign rem_gt_one = |remaining_q[WIDTH-1:1];

  assign step       = tick & ~hold;
  assign transition = step & rem_zero;
  assign load_ready = ~transition;
  assign load_fire  = load_valid & load_ready;

`ifdef PED_REQUEST_EN
  // A request seen at any clk during GREEN is remembered until the next step.
  logic ped_pending_q;
  logic ped_active;

  assign ped_active = ped_pending_q | ped_req;

  // Hold a GREEN pedestrian request until a step consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_pending_q <= 1'b0;
    end else if (step || (state_q != ST_GREEN)) begin
      ped_pending_q <= 1'b0;
    end else if (ped_req) begin
      ped_pending_q <= 1'b1;
    end
  end
`else
  logic ped_active;
  assign ped_active = 1'b0;
`endif

  // Duration of the phase that follows the current one.
  function automatic logic [WIDTH-1:0] next_dur(input state_t s,
                                                input logic [WIDTH-1:0] r,
                                                input logic [WIDTH-1:0] g,
                                                input logic [WIDTH-1:0] y);
    case (s)
      ST_RED:   next_dur = g;
      ST_GREEN: next_dur = y;
      default:  next_dur = r;
    endcase
  endfunction

  // Next-state and next-count logic.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    case (state_q)
      ST_RED, ST_GREEN, ST_YELLOW: begin
        if (transition) begin
          case (state_q)
            ST_RED:   state_d = ST_GREEN;
            ST_GREEN: state_d = ST_YELLOW;
            default:  state_d = ST_RED;
          endcase
          remaining_d = next_dur(state_q, dur_red_q, dur_green_q, dur_yellow_q);
          done_d      = 1'b1;
        end else if (step) begin
          if ((state_q == ST_GREEN) && rem_gt_one && ped_active) begin
            remaining_d = WIDTH'(1);
          end else begin
            remaining_d = rem_dec;
          end
        end
      end
      default: begin
        state_d     = ST_RED;
        remaining_d = dur_red_q;
      end
    endcase
  end

  // Phase, countdown and transition-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RED;
      remaining_q <= RED_DEF;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  // Duration registers written through the load port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dur_red_q    <= RED_DEF;
      dur_green_q  <= GREEN_DEF;
      dur_yellow_q <= YELLOW_DEF;
    end else if (load_fire) begin
      case (load_phase)
        2'b00:   dur_red_q    <= load_value;
        2'b01:   dur_green_q  <= load_value;
        2'b10:   dur_yellow_q <= load_value;
        default: ;
      endcase
    end
  end

  // Lamp decode from the registered phase, one-hot {red, yellow, green}.
  always_comb begin
    light = 3'b000;
    case (state_q)
      ST_RED:    light = 3'b100;
      ST_GREEN:  light = 3'b001;
      ST_YELLOW: light = 3'b010;
      default:   light = 3'b000;
    endcase
  end

  assign remaining = remaining_q;

  // The pulse is suppressed whenever the countdown is frozen.
  assign phase_done = done_q & ~hold;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_phase_timer
// Brief    : Directed, scoreboard-based bench for traffic_phase_timer.
//            Build with PED_REQUEST_EN to include the pedestrian scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       ped_req;
  logic       hold;
  logic       load_valid;
  logic       load_ready;
  logic [1:0] load_phase;
  logic [3:0] load_value;
  logic [2:0] light;
  logic [3:0] remaining;
  logic       phase_done;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;

  typedef struct packed {
    logic [2:0] light;
    logic [3:0] rem;
    logic       done;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state.
  logic [1:0] m_state;
  logic [3:0] m_rem;
  logic [3:0] m_dur [0:2];

  traffic_phase_timer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
`ifdef PED_REQUEST_EN
    .ped_req    (ped_req),
`endif
    .hold       (hold),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_phase (load_phase),
    .load_value (load_value),
    .light      (light),
    .remaining  (remaining),
    .phase_done (phase_done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [2:0] lamp(input logic [1:0] s);
    case (s)
      2'd0:    lamp = 3'b100;
      2'd1:    lamp = 3'b001;
      2'd2:    lamp = 3'b010;
      default: lamp = 3'b000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] req);
    tests++;
    assert (obs === req) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic model_reset();
    m_state  = 2'd0;
    m_rem    = 4'd9;
    m_dur[0] = 4'd9;
    m_dur[1] = 4'd9;
    m_dur[2] = 4'd2;
  endtask

  // One clock of stimulus; entered and left at a falling edge.
  task automatic drive(input logic t, input logic h, input logic lv,
                       input logic [1:0] lp, input logic [3:0] lval, input logic pr);
    logic   stp;
    logic   rdy;
    logic   trans;
    exp_t   e;
    exp_t   got;
    tick       = t;
    hold       = h;
    load_valid = lv;
    load_phase = lp;
    load_value = lval;
    ped_req    = pr;
    stp   = t & ~h;
    trans = stp && (m_rem == 4'd0);
    rdy   = ~trans;
    #1;
    chk("load_ready", {7'd0, load_ready}, {7'd0, rdy});
    if (trans) begin
      m_state = (m_state == 2'd2) ? 2'd0 : m_state + 2'd1;
      m_rem   = m_dur[m_state];
    end else if (stp) begin
`ifdef PED_REQUEST_EN
      if (m_state == 2'd1 && m_rem > 4'd1 && pr) m_rem = 4'd1;
      else m_rem = m_rem - 4'd1;
`else
      m_rem = m_rem - 4'd1;
`endif
    end
    if (lv && rdy && lp != 2'b11) m_dur[lp] = lval;
    e.light = lamp(m_state);
    e.rem   = m_rem;
    e.done  = trans;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got.light = light;
    got.rem   = remaining;
    got.done  = phase_done;
    if (phase_done === 1'b1) done_seen++;
    e = exp_q.pop_front();
    chk("light", {5'd0, got.light}, {5'd0, e.light});
    chk("remaining", {4'd0, got.rem}, {4'd0, e.rem});
    chk("phase_done", {7'd0, got.done}, {7'd0, e.done});
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
  endtask

  // Tick until the model reaches the requested phase/count, bounded.
  task automatic tick_until(input logic [1:0] s, input logic [3:0] r, input string tag);
    for (int k = 0; k < 60 && !(m_state == s && m_rem == r); k++)
      drive(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
    chk(tag, {4'd0, remaining}, {4'd0, r});
  endtask

  initial begin
    rst_n      = 1'b0;
    tick       = 1'b0;
    hold       = 1'b0;
    ped_req    = 1'b0;
    load_valid = 1'b0;
    load_phase = 2'b00;
    load_value = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state.
    chk("rst_light", {5'd0, light}, 8'h04);
    chk("rst_remaining", {4'd0, remaining}, 8'h09);
    chk("rst_phase_done", {7'd0, phase_done}, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Full cycle of defaults: 23 ticks, three pulses, back at RED 9.
    done_seen = 0;
    ticks(23);
    chk("period_pulses", done_seen[7:0], 8'd3);
    chk("period_light", {5'd0, light}, 8'h04);
    chk("period_remaining", {4'd0, remaining}, 8'h09);

    // Load GREEN=0 while RED counts; GREEN then lasts one tick.
    drive(1'b1, 1'b0, 1'b1, 2'b01, 4'd0, 1'b0);
    chk("red_unaffected", {4'd0, remaining}, 8'h08);
    for (int k = 0; k < 20 && m_state != 2'd1; k++) ticks(1);
    chk("green0_light", {5'd0, light}, 8'h01);
    chk("green0_remaining", {4'd0, remaining}, 8'h00);
    ticks(1);
    chk("green0_to_yellow", {5'd0, light}, 8'h02);
    chk("green0_second_pulse", {7'd0, phase_done}, 8'h01);

    // Hold at RED remaining=4 for five ticks.
    tick_until(2'd0, 4'd4, "reach_red4");
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, 1'b0, 2'b00, 4'd0, 1'b0);
    chk("hold_remaining", {4'd0, remaining}, 8'h04);
    chk("hold_light", {5'd0, light}, 8'h04);
    ticks(5);
    chk("after_hold_green", {5'd0, light}, 8'h01);

    // load_valid held across the GREEN->YELLOW transition.
    tick_until(2'd1, 4'd0, "reach_green0");
    drive(1'b1, 1'b0, 1'b1, 2'b10, 4'd5, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 2'b10, 4'd5, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 2'b11, 4'd0, 1'b0);
    for (int k = 0; k < 60 && !(m_state == 2'd2 && m_rem == 4'd5); k++) ticks(1);
    chk("yellow_loaded", {4'd0, remaining}, 8'h05);

    // Asynchronous reset mid-YELLOW at remaining=1.
    tick_until(2'd2, 4'd1, "reach_yellow1");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_light", {5'd0, light}, 8'h04);
    chk("async_remaining", {4'd0, remaining}, 8'h09);
    chk("async_phase_done", {7'd0, phase_done}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    done_seen = 0;
    ticks(10);
    chk("default_green", {4'd0, remaining}, 8'h09);
    ticks(13);
    chk("default_period", done_seen[7:0], 8'd3);

`ifdef PED_REQUEST_EN
    // Pedestrian request during GREEN at remaining=7.
    tick_until(2'd1, 4'd7, "reach_green7");
    drive(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 1'b1);
    chk("ped_remaining", {4'd0, remaining}, 8'h01);
    ticks(2);
    chk("ped_yellow", {5'd0, light}, 8'h02);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/traffic_phase_timer.md
Name: traffic_phase_timer

Overview:
Sequential counterpart to the 4-bit ripple adder. It is a down-counting phase timer for the traffic controller.
- Sequences RED -> GREEN -> YELLOW -> RED.
- Each phase lasts a programmable 4-bit number of ticks.
- The count decrements through a 4-bit borrow-chain subtractor (A - 1).
- Sits between the 1 Hz tick generator and the lamp drivers.
- Durations are programmed through a valid/ready load port.

Parameters:
- WIDTH, 4, counter and duration width.
- RED_DEF, 4'd9, reset duration of RED.
- GREEN_DEF, 4'd9, reset duration of GREEN.
- YELLOW_DEF, 4'd2, reset duration of YELLOW.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- tick  input  1  single-cycle count strobe.
- hold  input  1  freezes the countdown and the phase while high.
- load_valid  input  1  duration write request.
- load_ready  output  1  duration write can be accepted this cycle.
- load_phase  input  2  target phase: 00 RED, 01 GREEN, 10 YELLOW, 11 reserved.
- load_value  input  WIDTH  new duration in ticks.
- light  output  3  one-hot {red, yellow, green}.
- remaining  output  WIDTH  ticks left in the current phase.
- phase_done  output  1  one-cycle pulse on a phase transition.

Behaviour:
- Reset (async assert, sync release):
  - state=RED, light=3'b100, remaining=RED_DEF, phase_done=0.
  - Duration registers return to their *_DEF values.
  - A reset mid-phase aborts the phase immediately.
- The FSM has 3 states; 2-bit encoding RED=00, GREEN=01, YELLOW=10. Encoding 11 is illegal and recovers to RED on the next clk with remaining=dur[RED].
- Let step = tick & ~hold.
- step with remaining != 0:
  - remaining <= remaining - 1, computed as a borrow-chain subtract of 1.
  - No wrap occurs in this case.
- step with remaining == 0:
  - State advances to the next phase; remaining <= dur[next phase].
  - phase_done = 1 for exactly the following cycle.
  - light changes in that same cycle (registered outputs, latency 1 clk).
- Phase length is (duration + 1) ticks. Duration 0 gives a one-tick phase.
- hold high: remaining, state and light keep their values, and tick is ignored.
- load_ready = ~(step & (remaining == 0)), i.e. low only in a transition cycle.
- Load transfer happens on load_valid & load_ready:
  - dur[load_phase] <= load_value.
  - load_phase 11 is accepted (ready honoured) and has no effect.
- A new duration is used at the next entry into that phase. The current countdown is never modified.
- A load and a decrement in the same cycle are both performed.
- load_valid held during a transition cycle stalls one cycle and is accepted on the next cycle.
- phase_done never asserts during reset or while hold is high.

Optional Feature:
- Macro: PED_REQUEST_EN.
- Defined:
  - Adds input ped_req (1 bit), sampled every clk.
  - If state=GREEN and remaining > 1 and ped_req=1, then on the next step remaining <= 1 instead of decrementing.
  - The request is ignored in RED and YELLOW.
- Undefined: no ped_req port, and behaviour is exactly as above.

Test Plan:
- Reset with defaults, then tick every cycle:
  - RED 10 ticks, GREEN 10, YELLOW 3, back to RED.
  - remaining reads 9..0 in RED.
  - phase_done pulses 3 times per cycle of phases, total period 23 ticks.
- Load GREEN=0 during RED:
  - Current RED is unaffected.
  - GREEN then lasts 1 tick with remaining=0.
  - phase_done pulses on two consecutive ticks.
- hold=1 for 5 ticks at RED remaining=4:
  - remaining stays 4 and light stays 100.
  - After hold=0, 5 more ticks reach GREEN.
- load_valid held across a transition cycle:
  - load_ready=0 in that cycle only.
  - The write lands one cycle later.
  - load_phase=11 changes nothing.
- Assert rst_n=0 asynchronously mid-YELLOW (remaining=1):
  - light=100 and remaining=9 before the next clk edge.
  - Loaded durations revert to their defaults.
- With PED_REQUEST_EN, pulse ped_req during GREEN at remaining=7:
  - Next tick gives remaining=1.
  - Two more ticks reach YELLOW.
